// File: rtl/hazard_forward_ctrl.sv
// Hazard controller: EX-operand forwarding selects, load-use bubbles, and memory-wait freeze.
// Optional HAZARD_PERF_EN adds bubble/freeze cycle counters (stall_cnt_o, freeze_cnt_o).
module hazard_forward_ctrl #(
    parameter int unsigned REG_AW           = 5,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic              idex_regwrite_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_regwrite_i,
    input  logic              mem_busy_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       freeze_cnt_o,
`endif
    output logic              stall_o,
    output logic              bubble_o,
    output logic              freeze_o
);

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] LOAD_STALL = 2'd1;
    localparam logic [1:0] MEM_WAIT   = 2'd2;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic [1:0] pre_a, pre_b;
    logic       load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] ex_rd,
        input logic              ex_wr,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_wr
    );
        logic [1:0] sel;
        sel = FWD_RF;
        // The younger (EX) producer holds the newest value, so it is checked first.
        if (src != '0 && ex_wr && ex_rd == src) begin
            sel = FWD_EXMEM;
        end else if (src != '0 && mem_wr && mem_rd == src) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        pre_a = fwd_sel(ifid_rs_i, idex_rd_i, idex_regwrite_i, exmem_rd_i, exmem_regwrite_i);
        pre_b = fwd_sel(ifid_rt_i, idex_rd_i, idex_regwrite_i, exmem_rd_i, exmem_regwrite_i);
    end

    assign load_use = idex_memread_i && (idex_rd_i != '0) &&
                      ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        freeze_o = 1'b0;
        case (state_q)
            LOAD_STALL: begin
                if (mem_busy_i) begin
                    freeze_o = 1'b1;
                end else begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                    cnt_d    = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end
                end
            end
            // MEM_WAIT with the wait dropped behaves exactly like RUN.
            default: begin
                if (mem_busy_i) begin
                    freeze_o = 1'b1;
                    state_d  = MEM_WAIT;
                end else begin
                    state_d = RUN;
                    if (load_use) begin
                        stall_o  = 1'b1;
                        bubble_o = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = BUBBLE_RELOAD;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (freeze_o) begin
            fwd_a_d = fwd_a_q;
            fwd_b_d = fwd_b_q;
        end else if (bubble_o) begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end else begin
            fwd_a_d = pre_a;
            fwd_b_d = pre_b;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign forward_a_o = fwd_a_q;
    assign forward_b_o = fwd_b_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] freeze_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q  <= 32'd0;
            freeze_cnt_q <= 32'd0;
        end else begin
            if (bubble_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (freeze_o) freeze_cnt_q <= freeze_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign freeze_cnt_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: default-parameter DUT plus a 3-bubble DUT for reset mid-stall.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, idex_rd, exmem_rd;
    logic       idex_rw, idex_mr, exmem_rw, busy;

    logic [1:0] fa1, fb1, fa3, fb3;
    logic       st1, bu1, fr1, st3, bu3, fr3;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        bit         on3;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       bu;
        logic       fr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_forward_ctrl u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .ifid_rs_i(rs), .ifid_rt_i(rt),
        .idex_rd_i(idex_rd), .idex_regwrite_i(idex_rw), .idex_memread_i(idex_mr),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw), .mem_busy_i(busy),
        .forward_a_o(fa1), .forward_b_o(fb1),
        .stall_o(st1), .bubble_o(bu1), .freeze_o(fr1)
    );

    hazard_forward_ctrl #(.LOAD_USE_BUBBLES(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .ifid_rs_i(rs), .ifid_rt_i(rt),
        .idex_rd_i(idex_rd), .idex_regwrite_i(idex_rw), .idex_memread_i(idex_mr),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw), .mem_busy_i(busy),
        .forward_a_o(fa3), .forward_b_o(fb3),
        .stall_o(st3), .bubble_o(bu3), .freeze_o(fr3)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input bit on3, input logic [1:0] efa,
                             input logic [1:0] efb, input logic es, input logic eb,
                             input logic ef);
        chk({tag, ".fwd_a"}, on3 ? fa3 : fa1, efa);
        chk({tag, ".fwd_b"}, on3 ? fb3 : fb1, efb);
        chk({tag, ".stall"}, {1'b0, on3 ? st3 : st1}, {1'b0, es});
        chk({tag, ".bubble"}, {1'b0, on3 ? bu3 : bu1}, {1'b0, eb});
        chk({tag, ".freeze"}, {1'b0, on3 ? fr3 : fr1}, {1'b0, ef});
    endtask

    // Drive one cycle (called just after a rising edge), queue the expectation, compare mid-cycle.
    task automatic cyc(input string tag, input bit on3,
                       input logic [4:0] i_rs, input logic [4:0] i_rt,
                       input logic [4:0] i_exrd, input logic i_exrw, input logic i_exmr,
                       input logic [4:0] i_memrd, input logic i_memrw, input logic i_busy,
                       input logic [1:0] efa, input logic [1:0] efb,
                       input logic es, input logic eb, input logic ef);
        exp_t e;
        rs = i_rs; rt = i_rt;
        idex_rd = i_exrd; idex_rw = i_exrw; idex_mr = i_exmr;
        exmem_rd = i_memrd; exmem_rw = i_memrw; busy = i_busy;
        e.tag = tag; e.on3 = on3; e.fa = efa; e.fb = efb; e.st = es; e.bu = eb; e.fr = ef;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check_dut(e.tag, e.on3, e.fa, e.fb, e.st, e.bu, e.fr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rs = '0; rt = '0; idex_rd = '0; exmem_rd = '0;
        idex_rw = 1'b0; idex_mr = 1'b0; exmem_rw = 1'b0; busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_dut("reset1", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check_dut("reset3", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        //   tag           on3   rs     rt     exrd  exw   exm   memrd memw  busy  fa     fb     st bu fr
        cyc("alu_fwd",     1'b0, 5'd5,  5'd0,  5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 0);
        cyc("alu_fwd_ex",  1'b0, 5'd1,  5'd2,  5'd7, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 2'b10, 2'b00, 0, 0, 0);
        cyc("two_apart",   1'b0, 5'd0,  5'd5,  5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0);
        cyc("double",      1'b0, 5'd0,  5'd5,  5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 2'b00, 2'b01, 0, 0, 0);
        cyc("reg0",        1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 2'b00, 2'b10, 0, 0, 0);
        cyc("reg0_ex",     1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0);
        cyc("idle",        1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 0);
        // Load r3 in EX, dependent rs=r3 in ID.
        cyc("lu_hazard",   1'b0, 5'd3,  5'd4,  5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 1, 0);
        cyc("lu_after",    1'b0, 5'd3,  5'd4,  5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0);
        cyc("lu_dep_ex",   1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b00, 0, 0, 0);
        // Memory wait arriving together with a load-use hazard.
        cyc("mw_setup",    1'b0, 5'd8,  5'd0,  5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 0);
        cyc("mw_busy1",    1'b0, 5'd3,  5'd0,  5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 2'b10, 2'b00, 0, 0, 1);
        cyc("mw_busy2",    1'b0, 5'd3,  5'd0,  5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 2'b10, 2'b00, 0, 0, 1);
        cyc("mw_busy3",    1'b0, 5'd3,  5'd0,  5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 2'b10, 2'b00, 0, 0, 1);
        cyc("mw_bubble",   1'b0, 5'd3,  5'd0,  5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b10, 2'b00, 1, 1, 0);
        cyc("mw_after",    1'b0, 5'd3,  5'd0,  5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0);

        // Fresh reset before the 3-bubble scenario.
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("b3_hazard",   1'b1, 5'd3,  5'd0,  5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 1, 0);
        rs = 5'd3; rt = 5'd0; idex_rd = 5'd0; idex_rw = 1'b0; idex_mr = 1'b0;
        exmem_rd = 5'd3; exmem_rw = 1'b1; busy = 1'b0;
        @(negedge clk);
        check_dut("b3_bubble2", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_dut("b3_in_reset", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("b3_post_rst", 1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 0);
        cyc("b3_post2",    1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 0);
        cyc("b3_rehazard", 1'b1, 5'd3,  5'd0,  5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
